// File: rtl/dlx_instr_encoder_pkg.sv
// Shared DLX instruction field layout and serializer state encoding for the
// instruction encoder and its word FIFO.
package dlx_instr_encoder_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b0;

  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned RS1_HI  = 25;
  localparam int unsigned RS1_LO  = 21;
  localparam int unsigned RS2_HI  = 20;
  localparam int unsigned RS2_LO  = 16;
  localparam int unsigned RD_R_HI = 15;
  localparam int unsigned RD_R_LO = 11;
  localparam int unsigned RD_I_HI = 20;
  localparam int unsigned RD_I_LO = 16;
  localparam int unsigned FUNC_HI = 5;
  localparam int unsigned FUNC_LO = 0;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned IMM_LO  = 0;

  localparam logic [4:0] JLINK = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND0,
    ST_SEND1,
    ST_SEND2,
    ST_SEND3
  } ser_state_e;

  // Mirror of the IR decode: fields that do not exist for the format stay zero.
  function automatic logic [31:0] encode_word(
    input logic [5:0]  opc,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [5:0]  func,
    input logic [15:0] imm
  );
    logic [31:0] w;
    w = '0;
    w[OPC_HI:OPC_LO] = opc;
    w[RS1_HI:RS1_LO] = rs1;
    if (opc == OPC_RTYPE) begin
      w[RS2_HI:RS2_LO]   = rs2;
      w[RD_R_HI:RD_R_LO] = rd;
      w[FUNC_HI:FUNC_LO] = func;
    end else begin
      w[RD_I_HI:RD_I_LO] = rd;
      w[IMM_HI:IMM_LO]   = imm;
    end
    return w;
  endfunction

endpackage

// File: rtl/dlx_instr_encoder_word_fifo.sv
// Synchronous FIFO of encoded words with full/empty flags; pointers carry an
// extra wrap bit so full and empty are distinguishable.
module dlx_word_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_INC;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dlx_instr_encoder.sv
// Packs field-level DLX instruction requests into 32-bit words, buffers them
// and streams each word as four bytes over the 8-bit program-load interface.
module dlx_instr_encoder
  import dlx_instr_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [5:0]  OPC,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  input  logic [4:0]  RD,
  input  logic [5:0]  FUNC,
  input  logic [15:0] IMM,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  input  logic        BYTE_READY,
  output logic        BYTE_LAST,
  output logic [31:0] WORD_OUT,
  output logic        WORD_DONE,
  output logic [15:0] WORD_CNT
);

  ser_state_e  state_q, state_d;
  logic        fifo_full, fifo_empty;
  logic        push, pop, word_fin;
  logic [31:0] req_word, head_word, cur_word;
  logic [1:0]  idx;
  logic [7:0]  byte_sel;
  logic [31:0] word_out_q;
  logic        word_done_q;
  logic [15:0] word_cnt_q;

  // Ready follows only the registered full flag, so a pop never frees a slot
  // for a push on the same edge.
  assign REQ_READY = RESET_N & ~fifo_full;
  assign push      = REQ_VALID & REQ_READY;
  assign req_word  = encode_word(OPC, RS1, RS2, RD, FUNC, IMM);

  dlx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (req_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    word_fin   = 1'b0;
    BYTE_VALID = 1'b0;
    BYTE_LAST  = 1'b0;
    idx        = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SEND0;
        end
      end
      ST_SEND0: begin
        BYTE_VALID = 1'b1;
        if (BYTE_READY) state_d = ST_SEND1;
      end
      ST_SEND1: begin
        BYTE_VALID = 1'b1;
        idx        = 2'd1;
        if (BYTE_READY) state_d = ST_SEND2;
      end
      ST_SEND2: begin
        BYTE_VALID = 1'b1;
        idx        = 2'd2;
        if (BYTE_READY) state_d = ST_SEND3;
      end
      ST_SEND3: begin
        BYTE_VALID = 1'b1;
        BYTE_LAST  = 1'b1;
        idx        = 2'd3;
        if (BYTE_READY) begin
          word_fin = 1'b1;
          // Chain straight into the next queued word so there is no bubble.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_SEND0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    case (idx)
      2'd0:    byte_sel = (MSB_FIRST != 0) ? cur_word[31:24] : cur_word[7:0];
      2'd1:    byte_sel = (MSB_FIRST != 0) ? cur_word[23:16] : cur_word[15:8];
      2'd2:    byte_sel = (MSB_FIRST != 0) ? cur_word[15:8]  : cur_word[23:16];
      default: byte_sel = (MSB_FIRST != 0) ? cur_word[7:0]   : cur_word[31:24];
    endcase
  end

  assign BYTE_OUT = BYTE_VALID ? byte_sel : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_word    <= '0;
      word_out_q  <= '0;
      word_done_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (pop) cur_word <= head_word;
      word_done_q <= word_fin;
      if (word_fin) begin
        word_out_q <= cur_word;
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

  assign WORD_OUT  = word_out_q;
  assign WORD_DONE = word_done_q;
  assign WORD_CNT  = word_cnt_q;

endmodule
